dar_bank: RTL and testbench

- Parametrised successor of the single-port data/address register array.
- Configurable data width, depth and number of independent read ports.
- Read data is registered and qualified by a valid flag.
- A clear command sweeps the whole array to zero in the background and reports busy.
- Sits between the datapath controller and the ALU/bus; it is the team's standard scratch register storage.

---
 rtl/dar_pkg.sv | 28 ++
 rtl/dar_rd_port.sv | 76 +++++++
 rtl/dar_bank.sv | 113 +++++++++++
 tb/tb_dar_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dar_pkg.sv
// ============================================================================
// Module   : dar_pkg
// Brief    : Shared types, default sizes and address range helper for the
//            dar_bank register array and its read ports.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package dar_pkg;

  // Clear sweep controller states
  typedef enum logic [0:0] {
    DAR_IDLE  = 1'b0,
    DAR_CLEAR = 1'b1
  } dar_state_t;

  localparam int DAR_DATA_W = 8;
  localparam int DAR_ADDR_W = 7;
  localparam int DAR_DEPTH  = 128;

  // True when an address points at a real entry (DEPTH may be < 2**ADDR_W)
  function automatic logic dar_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dar_rd_port.sv
// ============================================================================
// Module   : dar_rd_port
// Brief    : One registered read port: storage mux, range check, zero gating
//            and optional same-cycle write forwarding (DAR_BANK_BYPASS_EN).
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module dar_rd_port
  import dar_pkg::*;
#(
  parameter int DATA_W = DAR_DATA_W,
  parameter int ADDR_W = DAR_ADDR_W,
  parameter int DEPTH  = DAR_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic                    wr_fire,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid
);

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] nxt_data;
  logic              in_range;
  logic              hit;

  assign in_range = dar_in_range(32'(addr), 32'(DEPTH));

`ifdef DAR_BANK_BYPASS_EN
  // A write committing this cycle to the same entry overrides the stored value
  assign hit = wr_fire && (wr_addr == addr);
`else
  // Read-first: the stored (pre-write) value is always returned
  assign hit = 1'b0;
  logic unused_fwd;
  assign unused_fwd = ^{wr_fire, wr_addr};
`endif

  // Select the addressed entry from the flattened storage
  always_comb begin
    word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        word = mem_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Idle ports and out-of-range addresses return zero
  always_comb begin
    nxt_data = '0;
    if (en && in_range) begin
      nxt_data = hit ? wr_data : word;
    end
  end

  // One-cycle registered read data and valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= nxt_data;
      rd_valid <= en;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dar_bank.sv
// ============================================================================
// Module   : dar_bank
// Brief    : Parametrised scratch register array with one write port, NRD
//            registered read ports and a background clear sweep.
//            Optional macro DAR_BANK_BYPASS_EN enables write-first forwarding.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module dar_bank
  import dar_pkg::*;
#(
  parameter int DATA_W = DAR_DATA_W,
  parameter int ADDR_W = DAR_ADDR_W,
  parameter int DEPTH  = DAR_DEPTH,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [NRD-1:0]        r_en,
  input  logic [NRD*ADDR_W-1:0] r_addr,
  output logic [NRD*DATA_W-1:0] r_data,
  output logic [NRD-1:0]        r_valid,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  w_drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dar_state_t              state;
  logic [ADDR_W-1:0]       idx;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic                    wr_fire;

  // A write lands only in IDLE, in range, and when no clear is starting
  assign wr_fire = (state == DAR_IDLE) && w_en && !clr_req &&
                   dar_in_range(32'(w_addr), 32'(DEPTH));

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign mem_flat[i*DATA_W +: DATA_W] = mem[i];
    end
  endgenerate

  // Storage, write port and clear sweep controller with registered flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state  <= DAR_IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      w_drop <= 1'b0;
    end else begin
      // Any requested write that does not commit is reported as dropped
      w_drop <= w_en && !wr_fire;
      case (state)
        DAR_IDLE: begin
          if (clr_req) begin
            state <= DAR_CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (wr_fire) begin
            mem[w_addr] <= w_data;
          end
        end
        DAR_CLEAR: begin
          mem[idx] <= '0;
          if (idx == LAST_IDX) begin
            state <= DAR_IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= DAR_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      dar_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_rd (
        .clk      (clk),
        .rst      (rst),
        .en       (r_en[k]),
        .addr     (r_addr[k*ADDR_W +: ADDR_W]),
        .mem_flat (mem_flat),
        .wr_fire  (wr_fire),
        .wr_addr  (w_addr),
        .wr_data  (w_data),
        .rd_data  (r_data[k*DATA_W +: DATA_W]),
        .rd_valid (r_valid[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dar_bank.sv
// ============================================================================
// Module   : tb_dar_bank
// Brief    : Self-checking bench for dar_bank (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dar_bank;

  localparam int DEPTH = 128;
`ifdef DAR_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit [7:0] SAME_CYC = BYP ? 8'h11 : 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0;
  logic [6:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic [1:0]  r_en = '0;
  logic [13:0] r_addr = '0;
  logic [15:0] r_data;
  logic [1:0]  r_valid;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        w_drop;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: array contents plus a sweep position
  bit [7:0] mdl [DEPTH];
  bit       sweeping = 1'b0;
  int       sweep_pos = 0;

  always #5 clk = ~clk;

  dar_bank #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .NRD(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_en    (r_en),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .r_valid (r_valid),
    .clr_req (clr_req),
    .busy    (busy),
    .w_drop  (w_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    sweeping  = 1'b0;
    sweep_pos = 0;
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs
  task automatic step(input bit we, input bit [6:0] wa, input bit [7:0] wd,
                      input bit [1:0] re, input bit [6:0] ra0, input bit [6:0] ra1,
                      input bit clr);
    bit       drop;
    bit       acc;
    bit [7:0] xd [2];
    bit [6:0] ra [2];
    w_en = we; w_addr = wa; w_data = wd;
    r_en = re; r_addr = {ra1, ra0}; clr_req = clr;
    @(posedge clk);
    ra[0] = ra0;
    ra[1] = ra1;
    drop = we && (sweeping || clr || int'(wa) >= DEPTH);
    acc  = we && !drop;
    for (int k = 0; k < 2; k++) begin
      if (!re[k] || int'(ra[k]) >= DEPTH) xd[k] = 8'h00;
      else if (BYP && acc && wa == ra[k]) xd[k] = wd;
      else xd[k] = mdl[ra[k]];
    end
    if (sweeping) begin
      mdl[sweep_pos] = 8'h00;
      sweep_pos++;
      if (sweep_pos == DEPTH) sweeping = 1'b0;
    end else if (clr) begin
      sweeping  = 1'b1;
      sweep_pos = 0;
    end else if (acc) begin
      mdl[wa] = wd;
    end
    #1;
    chk("busy",    busy,         sweeping);
    chk("w_drop",  w_drop,       drop);
    chk("r_valid", r_valid,      re);
    chk("r_data0", r_data[7:0],  xd[0]);
    chk("r_data1", r_data[15:8], xd[1]);
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 8'd0, 2'b00, 7'd0, 7'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 300) begin
      idle();
      guard++;
    end
    chk("wait_idle_timeout", busy, 1'b0);
  endtask

  typedef struct {
    bit       we;
    bit [6:0] wa;
    bit [7:0] wd;
    bit [1:0] re;
    bit [6:0] ra0;
    bit [6:0] ra1;
    bit [1:0] xrv;
    bit [7:0] xd0;
    bit [7:0] xd1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int cnt;
    int s;
    bit [6:0] a0, a1;

    tbl[0] = '{1'b1, 7'd3, 8'hA5, 2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 7'd0, 8'h00, 2'b01, 7'd3, 7'd0, 2'b01, 8'hA5, 8'h00};
    tbl[2] = '{1'b1, 7'd5, 8'h11, 2'b10, 7'd0, 7'd5, 2'b10, 8'h00, SAME_CYC};
    tbl[3] = '{1'b0, 7'd0, 8'h00, 2'b10, 7'd0, 7'd5, 2'b10, 8'h00, 8'h11};
    tbl[4] = '{1'b1, 7'd7, 8'h3C, 2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00};
    tbl[5] = '{1'b0, 7'd0, 8'h00, 2'b11, 7'd7, 7'd7, 2'b11, 8'h3C, 8'h3C};
    tbl[6] = '{1'b0, 7'd0, 8'h00, 2'b00, 7'd7, 7'd7, 2'b00, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 7'd0, 8'h00, 2'b11, 7'd3, 7'd0, 2'b11, 8'hA5, 8'h00};

    // Reset state
    model_reset();
    #2 rst = 1'b0;
    #10;
    chk("rst_busy",    busy,    1'b0);
    chk("rst_w_drop",  w_drop,  1'b0);
    chk("rst_r_valid", r_valid, 2'b00);
    chk("rst_r_data",  r_data,  16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1, 1'b0);
      chk("tbl_r_valid", r_valid,      tbl[i].xrv);
      chk("tbl_r_data0", r_data[7:0],  tbl[i].xd0);
      chk("tbl_r_data1", r_data[15:8], tbl[i].xd1);
    end

    // Fill with addr^0xFF, then clear with a colliding write
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, 7'(a), 8'(a) ^ 8'hFF, 2'b00, 7'd0, 7'd0, 1'b0);
    end
    step(1'b1, 7'd9, 8'h55, 2'b00, 7'd0, 7'd0, 1'b1);
    chk("drop_on_clr", w_drop, 1'b1);
    chk("busy_start",  busy,   1'b1);
    cnt = busy ? 1 : 0;
    s = 0;
    while (busy && s < 300) begin
      step(s == 10, 7'd120, 8'h77, (s == 50) ? 2'b01 : 2'b00, 7'd100, 7'd0, 1'b0);
      if (s == 10) chk("drop_busy", w_drop, 1'b1);
      if (s == 11) chk("drop_once", w_drop, 1'b0);
      if (s == 50) chk("sweep_rd100", r_data[7:0], 8'h9B);
      s++;
      if (busy) cnt++;
    end
    chk("busy_cycles", cnt, 128);
    for (int a = 0; a < DEPTH; a += 2) begin
      step(1'b0, 7'd0, 8'd0, 2'b11, 7'(a), 7'(a + 1), 1'b0);
    end
    step(1'b0, 7'd0, 8'd0, 2'b11, 7'd9, 7'd120, 1'b0);
    chk("post_clr_9",   r_data[7:0],  8'h00);
    chk("post_clr_120", r_data[15:8], 8'h00);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom),
           2'($urandom), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
           $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset in the middle of a sweep
    wait_idle();
    step(1'b1, 7'd127, 8'hC3, 2'b00, 7'd0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 8'd0, 2'b00, 7'd0, 7'd0, 1'b1);
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 7'd0, 8'd0, 2'b11, 7'd127, 7'd127, 1'b0);
    end
    chk("pre_rst_rd127", r_data[7:0], 8'hC3);
    #3 rst = 1'b0;
    #1;
    chk("async_busy",    busy,    1'b0);
    chk("async_r_valid", r_valid, 2'b00);
    chk("async_r_data",  r_data,  16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    step(1'b0, 7'd0, 8'd0, 2'b11, 7'd127, 7'd0, 1'b0);
    chk("after_rst_rd127", r_data[7:0], 8'h00);
    chk("after_rst_busy",  busy,        1'b0);
    step(1'b1, 7'd64, 8'h5A, 2'b00, 7'd0, 7'd0, 1'b0);
    chk("after_rst_wr_ok", w_drop, 1'b0);
    step(1'b0, 7'd0, 8'd0, 2'b10, 7'd0, 7'd64, 1'b0);
    chk("after_rst_rd64", r_data[15:8], 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
